// File: rtl/dac_bias_sequencer.sv
// dac_bias_sequencer: steps the DAC Vbias controls and the pattern mode
// select through {mode, bias} combinations. Changes are applied only at the
// rising edge of vblank, so every visible frame uses a single setting.
module dac_bias_sequencer #(
    parameter int LAST_INDEX = 63,
    parameter int DWELL_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vblank,
    input  logic               src_sel,
    input  logic               auto_en,
    input  logic               wrap_en,
    input  logic               restart,
    input  logic               step_req,
    input  logic [DWELL_W-1:0] dwell_frames,
    input  logic [2:0]         manual_bias,
    input  logic [2:0]         manual_mode,
    output logic [2:0]         bias_out,
    output logic [2:0]         mode_out,
    output logic [5:0]         seq_index,
    output logic               step_ack,
    output logic               done,
    output logic               busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [5:0] LAST = 6'(LAST_INDEX);

    state_t             state_q, state_d;
    logic [5:0]         seq_index_q, seq_index_d;
    logic [DWELL_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               step_pending_q, step_pending_d;
    logic               step_ack_q, step_ack_d;
    logic               vb_q;
    logic [2:0]         bias_q, bias_d;
    logic [2:0]         mode_q, mode_d;

    logic               rise;
    logic               step_now;
    logic [DWELL_W-1:0] dwell_last;
    logic [5:0]         adv_index;

    // Frame edge, effective dwell length and the "next index" of an advance.
    // adv_index clamps with >= so the index can never leave 0..LAST_INDEX.
    assign rise       = vblank & ~vb_q;
    assign step_now   = step_pending_q | step_req;
    assign dwell_last = (dwell_frames == '0) ? '0 : (dwell_frames - DWELL_W'(1));
    assign adv_index  = (seq_index_q >= LAST) ? 6'd0 : (seq_index_q + 6'd1);

    // State and datapath registers; rst overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            seq_index_q    <= '0;
            frame_cnt_q    <= '0;
            step_pending_q <= 1'b0;
            step_ack_q     <= 1'b0;
            vb_q           <= 1'b0;
            bias_q         <= '0;
            mode_q         <= '0;
        end else begin
            state_q        <= state_d;
            seq_index_q    <= seq_index_d;
            frame_cnt_q    <= frame_cnt_d;
            step_pending_q <= step_pending_d;
            step_ack_q     <= step_ack_d;
            vb_q           <= vblank;
            bias_q         <= bias_d;
            mode_q         <= mode_d;
        end
    end

    // Next-state and index/counter update; restart is applied last so it
    // wins over any advance or step decided in the same cycle.
    always_comb begin
        state_d        = state_q;
        seq_index_d    = seq_index_q;
        frame_cnt_d    = frame_cnt_q;
        step_pending_d = step_pending_q;
        step_ack_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (auto_en) begin
                    state_d        = ST_DWELL;
                    frame_cnt_d    = '0;
                    step_pending_d = 1'b0;
                end else begin
                    step_pending_d = step_now;
                    if (rise && step_now) begin
                        seq_index_d    = adv_index;
                        step_pending_d = 1'b0;
                        step_ack_d     = 1'b1;
                    end
                end
            end
            ST_DWELL: begin
                step_pending_d = 1'b0;
                if (!auto_en) begin
                    state_d     = ST_IDLE;
                    frame_cnt_d = '0;
                end else if (rise) begin
                    if (frame_cnt_q >= dwell_last) begin
                        frame_cnt_d = '0;
                        if ((seq_index_q >= LAST) && !wrap_en) begin
                            state_d = ST_DONE;
                        end else begin
                            seq_index_d = adv_index;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + DWELL_W'(1);
                    end
                end
            end
            ST_DONE: begin
                step_pending_d = 1'b0;
                if (!auto_en) begin
                    state_d = ST_IDLE;
                end else if (restart) begin
                    state_d = ST_DWELL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (restart) begin
            seq_index_d    = '0;
            frame_cnt_d    = '0;
            step_pending_d = 1'b0;
            step_ack_d     = 1'b0;
        end

        bias_d = bias_q;
        mode_d = mode_q;
        if (rise) begin
            bias_d = src_sel ? seq_index_d[2:0] : manual_bias;
            mode_d = src_sel ? seq_index_d[5:3] : manual_mode;
        end
    end

    // Outputs: registered settings plus state decode.
    always_comb begin
        bias_out  = bias_q;
        mode_out  = mode_q;
        seq_index = seq_index_q;
        step_ack  = step_ack_q;
        busy      = (state_q == ST_DWELL);
        done      = (state_q == ST_DONE);
    end

endmodule

// File: tb/tb_dac_bias_sequencer.sv
// Scoreboard bench for dac_bias_sequencer: two instances (LAST_INDEX 63 and 5)
// share the stimulus; expected outputs are queued before each vblank rise and
// compared one cycle after it.
module tb_dac_bias_sequencer;

    logic       clk;
    logic       rst;
    logic       vblank;
    logic       src_sel;
    logic       auto_en;
    logic       wrap_en;
    logic       restart;
    logic       step_req;
    logic [7:0] dwell_frames;
    logic [2:0] manual_bias;
    logic [2:0] manual_mode;

    logic [2:0] bias_a, mode_a, bias_b, mode_b;
    logic [5:0] idx_a, idx_b;
    logic       ack_a, done_a, busy_a, ack_b, done_b, busy_b;

    int total_cnt = 0;
    int bad_cnt   = 0;

    typedef struct {
        int         tid;
        bit         which;
        logic [2:0] bias;
        logic [2:0] mode;
        logic [5:0] idx;
        logic       ack;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb_q[$];

    dac_bias_sequencer #(.LAST_INDEX(63), .DWELL_W(8)) u_dut_a (
        .clk(clk), .rst(rst), .vblank(vblank), .src_sel(src_sel),
        .auto_en(auto_en), .wrap_en(wrap_en), .restart(restart),
        .step_req(step_req), .dwell_frames(dwell_frames),
        .manual_bias(manual_bias), .manual_mode(manual_mode),
        .bias_out(bias_a), .mode_out(mode_a), .seq_index(idx_a),
        .step_ack(ack_a), .done(done_a), .busy(busy_a)
    );

    dac_bias_sequencer #(.LAST_INDEX(5), .DWELL_W(8)) u_dut_b (
        .clk(clk), .rst(rst), .vblank(vblank), .src_sel(src_sel),
        .auto_en(auto_en), .wrap_en(wrap_en), .restart(restart),
        .step_req(step_req), .dwell_frames(dwell_frames),
        .manual_bias(manual_bias), .manual_mode(manual_mode),
        .bias_out(bias_b), .mode_out(mode_b), .seq_index(idx_b),
        .step_ack(ack_b), .done(done_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int tid, input bit which, input logic [5:0] idx,
                            input logic [2:0] b, input logic [2:0] m,
                            input logic ack, input logic bsy, input logic dn);
        exp_t e;
        e.tid = tid; e.which = which; e.idx = idx; e.bias = b; e.mode = m;
        e.ack = ack; e.busy = bsy; e.done = dn;
        sb_q.push_back(e);
    endtask

    task automatic push_idx(input int tid, input bit which, input logic [5:0] idx,
                            input logic ack, input logic bsy, input logic dn);
        push_exp(tid, which, idx, idx[2:0], idx[5:3], ack, bsy, dn);
    endtask

    // One vblank pulse; the queued expectation is compared one cycle after the rise.
    task automatic frame(input int hold, input bit with_step);
        exp_t e;
        vblank   = 1'b1;
        step_req = with_step;
        tick();
        step_req = 1'b0;
        if (sb_q.size() == 0) begin
            check_val("scoreboard_empty", 1, 0);
        end else begin
            e = sb_q.pop_front();
            check_val($sformatf("t%0d_bias", e.tid), e.which ? bias_b : bias_a, e.bias);
            check_val($sformatf("t%0d_mode", e.tid), e.which ? mode_b : mode_a, e.mode);
            check_val($sformatf("t%0d_idx", e.tid),  e.which ? idx_b  : idx_a,  e.idx);
            check_val($sformatf("t%0d_ack", e.tid),  e.which ? ack_b  : ack_a,  e.ack);
            check_val($sformatf("t%0d_busy", e.tid), e.which ? busy_b : busy_a, e.busy);
            check_val($sformatf("t%0d_done", e.tid), e.which ? done_b : done_a, e.done);
            $display("txn t%0d dut%0d idx=%0d bias=%0d mode=%0d", e.tid, e.which,
                     e.which ? idx_b : idx_a, e.which ? bias_b : bias_a,
                     e.which ? mode_b : mode_a);
            tick();
            check_val($sformatf("t%0d_ack_1cyc", e.tid), e.which ? ack_b : ack_a, 0);
        end
        repeat (hold) tick();
        vblank = 1'b0;
        repeat (2) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; vblank = 1'b0; src_sel = 1'b0; auto_en = 1'b0; wrap_en = 1'b0;
        restart = 1'b0; step_req = 1'b0; dwell_frames = 8'd0;
        manual_bias = 3'd0; manual_mode = 3'd0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin
        // T1: reset state and manual pass-through
        do_reset();
        check_val("rst_bias", bias_a, 0);
        check_val("rst_mode", mode_a, 0);
        check_val("rst_idx", idx_a, 0);
        check_val("rst_ack", ack_a, 0);
        check_val("rst_busy", busy_a, 0);
        check_val("rst_done", done_a, 0);
        manual_bias = 3'b101; manual_mode = 3'b010;
        tick();
        vblank = 1'b1;
        #1;
        check_val("t1_pre_rise_bias", bias_a, 0);
        push_exp(1, 0, 6'd0, 3'b101, 3'b010, 0, 0, 0);
        frame(1, 0);
        manual_bias = 3'b011; manual_mode = 3'b110;
        repeat (3) tick();
        check_val("t1_hold_bias", bias_a, 5);
        check_val("t1_hold_mode", mode_a, 2);
        push_exp(1, 0, 6'd0, 3'b011, 3'b110, 0, 0, 0);
        frame(4, 0);

        // T2: auto dwell 3 with wrap over the full 64-entry sequence
        do_reset();
        src_sel = 1'b1; auto_en = 1'b1; dwell_frames = 8'd3; wrap_en = 1'b1;
        tick();
        for (int k = 1; k <= 192; k++) begin
            push_idx(2, 0, 6'((k / 3) % 64), 0, 1, 0);
            frame((k % 5 == 0) ? 4 : 0, 0);
            if (k == 39) begin
                check_val("t2_idx13_bias", bias_a, 3'b101);
                check_val("t2_idx13_mode", mode_a, 3'b001);
            end
        end

        // T3: dwell 0 acts as 1, no wrap, stop at LAST_INDEX=5 then restart
        do_reset();
        src_sel = 1'b1; auto_en = 1'b1; dwell_frames = 8'd0; wrap_en = 1'b0;
        tick();
        for (int k = 1; k <= 5; k++) begin
            push_idx(3, 1, 6'(k), 0, 1, 0);
            frame(0, 0);
        end
        push_idx(3, 1, 6'd5, 0, 0, 1);
        frame(0, 0);
        push_idx(3, 1, 6'd5, 0, 0, 1);
        frame(2, 0);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check_val("t3_restart_idx", idx_b, 0);
        check_val("t3_restart_busy", busy_b, 1);
        check_val("t3_restart_done", done_b, 0);
        check_val("t3_restart_bias_held", bias_b, 5);
        push_idx(3, 1, 6'd1, 0, 1, 0);
        frame(0, 0);

        // T4: host steps, mid-frame and coincident with the rise
        do_reset();
        src_sel = 1'b1;
        tick();
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        repeat (2) tick();
        check_val("t4_no_rise_idx", idx_a, 0);
        check_val("t4_no_rise_ack", ack_a, 0);
        push_idx(4, 0, 6'd1, 1, 0, 0);
        frame(0, 0);
        push_idx(4, 0, 6'd2, 1, 0, 0);
        frame(0, 1);
        push_idx(4, 0, 6'd2, 0, 0, 0);
        frame(0, 0);

        // T5: auto_en dropped mid-dwell clears frame_cnt, keeps index
        do_reset();
        src_sel = 1'b1; auto_en = 1'b1; dwell_frames = 8'd4; wrap_en = 1'b1;
        tick();
        for (int k = 1; k <= 6; k++) begin
            push_idx(5, 0, 6'(k / 4), 0, 1, 0);
            frame(0, 0);
        end
        auto_en = 1'b0;
        tick();
        check_val("t5_idle_busy", busy_a, 0);
        check_val("t5_idle_idx", idx_a, 1);
        auto_en = 1'b1;
        tick();
        for (int k = 1; k <= 4; k++) begin
            push_idx(5, 0, (k == 4) ? 6'd2 : 6'd1, 0, 1, 0);
            frame(0, 0);
        end

        // T6: reset in the middle of a dwell at index 20
        do_reset();
        src_sel = 1'b1; auto_en = 1'b1; dwell_frames = 8'd1; wrap_en = 1'b1;
        tick();
        for (int k = 1; k <= 20; k++) begin
            push_idx(6, 0, 6'(k), 0, 1, 0);
            frame(0, 0);
        end
        rst = 1'b1;
        tick();
        check_val("t6_rst_bias", bias_a, 0);
        check_val("t6_rst_mode", mode_a, 0);
        check_val("t6_rst_idx", idx_a, 0);
        check_val("t6_rst_ack", ack_a, 0);
        check_val("t6_rst_busy", busy_a, 0);
        check_val("t6_rst_done", done_a, 0);
        rst = 1'b0;
        tick();
        check_val("t6_sb_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
